systolic_feeder_2x2: RTL and testbench
======================================

Name: systolic_feeder_2x2

Overview:
Sequencer that drives a 2x2 output-stationary systolic array (WIDTH-bit signed operands, 2*WIDTH-bit accumulators) with correctly skewed operand streams and collects its results. Host loads A and B (2x2 each) through a byte-wide write port and pulses start. The FSM clears the array, feeds three skewed beats, waits for drain, then latches C and presents it on a valid/ready result interface. Sits between the host/register bus and the array instance.

Parameters:
WIDTH, 8, operand width; results are 2*WIDTH
DRAIN_CYCLES, 2, cycles waited after last feed beat before capturing C (>=2; array pipeline depth)

Ports:
clk  input  1  clock; all logic on rising edge
rst  input  1  synchronous active-low reset (0 = reset)
load_en  input  1  write strobe for matrix registers
load_addr  input  3  0..3 = A00,A01,A10,A11; 4..7 = B00,B01,B10,B11
load_data  input  WIDTH  signed operand to write
start  input  1  begin job (single-cycle pulse; level treated as pulse per accepted cycle)
relu_en  input  1  ReLU request, sampled with start
busy  output  1  high from accepted start until result handshake completes
clear  output  1  array accumulator clear
activation  output  1  array ReLU select, held for whole job
a_data0  output  WIDTH  array row-0 operand
a_data1  output  WIDTH  array row-1 operand
b_data0  output  WIDTH  array col-0 operand
b_data1  output  WIDTH  array col-1 operand
c00, c01, c10, c11  input  2*WIDTH each  array results
res_valid  output  1  result valid
res_ready  input  1  consumer ready
r00, r01, r10, r11  output  2*WIDTH each  captured results

Behaviour:
- Reset (rst=0 at edge): state IDLE; matrix regs, r00..r11, a/b outputs, clear, activation, busy, res_valid all 0.
- States: IDLE -> CLEAR -> FEED(step 0..2) -> DRAIN(DRAIN_CYCLES) -> DONE -> IDLE.
- IDLE: load_en writes matrix reg at load_addr. start=1 latches relu_en into activation, goes to CLEAR. Load and start in same cycle: write commits and is used by the job.
- CLEAR: clear=1 for exactly one cycle; a/b outputs 0.
- FEED beats (skew): step0: a0=A00, a1=0, b0=B00, b1=0. step1: a0=A01, a1=A10, b0=B10, b1=B01. step2: a0=0, a1=A11, b0=0, b1=B11.
- DRAIN: a/b outputs 0. At final DRAIN edge, r_ij <= c_ij; go DONE.
- DONE: res_valid=1; r regs stable. res_valid&&res_ready -> IDLE, res_valid=0 next cycle.
- Latency: start accepted at edge 0 -> clear in cycle 1, feed cycles 2-4, res_valid first high in cycle 5+DRAIN_CYCLES (7 by default).
- busy=1 in all states except IDLE. activation held from start through DONE; drops to 0 on return to IDLE.
- While busy: load_en ignored (registers unchanged), start ignored (no re-trigger, no queueing).
- Matrix regs persist across jobs; re-start without reload reuses them.
- Reset mid-job: immediate return to IDLE with all reset values; next job requires reload.
- No arithmetic in block; results pass through unchanged (ReLU applied in array).

Optional Feature:
SYSTOLIC_FEEDER_JOBCNT_EN: adds output job_count (16 bits), incremented on each result handshake, wraps 0xFFFF->0, cleared by reset. Undefined: port and counter absent; behaviour otherwise identical.

Test Plan:
- A=[[1,2],[3,4]], B=[[5,6],[7,8]], relu_en=0, res_ready=1 -> res_valid in cycle 7 after start; r00=19, r01=22, r10=43, r11=50; busy low next cycle.
- Monitor a/b ports for above job -> clear only in cycle 1; beats exactly (1,0,5,0), (2,3,7,6), (0,4,0,8); zeros elsewhere.
- A=[[-1,0],[0,1]], B=[[2,0],[0,3]], relu_en=1 -> r00=0, r11=3, activation=1 throughout; same job relu_en=0 -> r00=0xFFFE (16-bit).
- res_ready=0 for 5 cycles in DONE -> res_valid and r values held; start and load_en pulses meanwhile ignored (regs unchanged, no second job).
- rst=0 during feed step1 -> next cycle all outputs 0, state IDLE; fresh load+start gives correct result.
- With SYSTOLIC_FEEDER_JOBCNT_EN: three completed jobs -> job_count=3; reset -> 0.

Source files
------------

// File: rtl/systolic_feeder_2x2_if.sv
// ---------------------------------------------------------------------------
// systolic_feeder_2x2_if
//
// Host-side bundle of the 2x2 systolic feeder: the byte-wide matrix write
// port, the job start request and the valid/ready result channel.
//
// Signals:
//   load_en / load_addr / load_data  matrix register write (A at 0..3, B at 4..7)
//   start / relu_en                  job request and its ReLU selection
//   busy                             feeder is running a job or holding a result
//   res_valid / res_ready            result handshake
//   r00..r11                         captured 2*WIDTH-bit results
//
// Modports:
//   master  host / register-bus side (drives writes, start, res_ready)
//   slave   feeder side (drives busy, res_valid and the results)
// ---------------------------------------------------------------------------
interface systolic_feeder_2x2_if #(
  parameter int WIDTH = 8
);

  logic                 load_en;
  logic [2:0]           load_addr;
  logic [WIDTH-1:0]     load_data;
  logic                 start;
  logic                 relu_en;
  logic                 busy;
  logic                 res_valid;
  logic                 res_ready;
  logic [2*WIDTH-1:0]   r00;
  logic [2*WIDTH-1:0]   r01;
  logic [2*WIDTH-1:0]   r10;
  logic [2*WIDTH-1:0]   r11;

  modport master (
    output load_en, load_addr, load_data, start, relu_en, res_ready,
    input  busy, res_valid, r00, r01, r10, r11
  );

  modport slave (
    input  load_en, load_addr, load_data, start, relu_en, res_ready,
    output busy, res_valid, r00, r01, r10, r11
  );

endinterface

// File: rtl/systolic_feeder_2x2.sv
// ---------------------------------------------------------------------------
// systolic_feeder_2x2
//
// Sequencer for a 2x2 output-stationary systolic array. The host writes the
// 2x2 operand matrices A and B through the interface write port and pulses
// start. The feeder then clears the array, streams three skewed operand beats
// into its row/column inputs, waits DRAIN_CYCLES for the array pipeline to
// settle, captures the four accumulators and offers them on a valid/ready
// result channel. No arithmetic is done here; ReLU is applied inside the
// array, the feeder only holds the activation select steady for the job.
//
// Parameters:
//   WIDTH         operand width (results are 2*WIDTH)
//   DRAIN_CYCLES  wait after the last feed beat before capture (>= 2)
//
// Ports:
//   clk                  clock, rising edge
//   rst                  synchronous active-low reset (0 = reset)
//   host                 systolic_feeder_2x2_if.slave (writes, start, results)
//   clear                one-cycle accumulator clear to the array
//   activation           ReLU select to the array, held for the whole job
//   a_data0 / a_data1    row-0 / row-1 operand streams
//   b_data0 / b_data1    column-0 / column-1 operand streams
//   c00..c11             array accumulator outputs
//   job_count            (only with SYSTOLIC_FEEDER_JOBCNT_EN) number of
//                        completed result handshakes, 16-bit wrapping
//
// Optional feature macro: SYSTOLIC_FEEDER_JOBCNT_EN
// ---------------------------------------------------------------------------
module systolic_feeder_2x2 #(
  parameter int WIDTH        = 8,
  parameter int DRAIN_CYCLES = 2
) (
  input  logic                clk,
  input  logic                rst,
  systolic_feeder_2x2_if.slave host,
  output logic                clear,
  output logic                activation,
  output logic [WIDTH-1:0]    a_data0,
  output logic [WIDTH-1:0]    a_data1,
  output logic [WIDTH-1:0]    b_data0,
  output logic [WIDTH-1:0]    b_data1,
  input  logic [2*WIDTH-1:0]  c00,
  input  logic [2*WIDTH-1:0]  c01,
  input  logic [2*WIDTH-1:0]  c10,
  input  logic [2*WIDTH-1:0]  c11
`ifdef SYSTOLIC_FEEDER_JOBCNT_EN
  ,
  output logic [15:0]         job_count
`endif
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_CLEAR = 3'd1;
  localparam logic [2:0] S_FEED  = 3'd2;
  localparam logic [2:0] S_DRAIN = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  localparam logic [1:0] LAST_STEP  = 2'd2;
  localparam logic [7:0] DRAIN_LAST = 8'(DRAIN_CYCLES - 1);

  // Matrix register file: index 0..3 = A00,A01,A10,A11; 4..7 = B00,B01,B10,B11
  localparam int A00 = 0;
  localparam int A01 = 1;
  localparam int A10 = 2;
  localparam int A11 = 3;
  localparam int B00 = 4;
  localparam int B01 = 5;
  localparam int B10 = 6;
  localparam int B11 = 7;

  logic [2:0]          state;
  logic [1:0]          step;
  logic [7:0]          drain_cnt;
  logic [WIDTH-1:0]    mat [8];
  logic [2*WIDTH-1:0]  r00_q;
  logic [2*WIDTH-1:0]  r01_q;
  logic [2*WIDTH-1:0]  r10_q;
  logic [2*WIDTH-1:0]  r11_q;
  logic                handshake;

  assign handshake = (state == S_DONE) && host.res_ready;

  // Job sequencing, matrix writes and result capture. Writes and start are
  // only honoured in IDLE, so a write arriving together with start lands in
  // the register file before CLEAR and is seen by the job it starts.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= S_IDLE;
      step       <= 2'd0;
      drain_cnt  <= 8'd0;
      activation <= 1'b0;
      r00_q      <= '0;
      r01_q      <= '0;
      r10_q      <= '0;
      r11_q      <= '0;
      for (int i = 0; i < 8; i++) begin
        mat[i] <= '0;
      end
    end else begin
      case (state)
        S_IDLE: begin
          if (host.load_en) begin
            mat[host.load_addr] <= host.load_data;
          end
          if (host.start) begin
            activation <= host.relu_en;
            state      <= S_CLEAR;
          end
        end
        S_CLEAR: begin
          step  <= 2'd0;
          state <= S_FEED;
        end
        S_FEED: begin
          if (step == LAST_STEP) begin
            drain_cnt <= 8'd0;
            state     <= S_DRAIN;
          end else begin
            step <= step + 2'd1;
          end
        end
        S_DRAIN: begin
          // PE11 sees its last product one beat after the feed ends, so
          // the capture must wait for the full pipeline depth.
          if (drain_cnt == DRAIN_LAST) begin
            r00_q <= c00;
            r01_q <= c01;
            r10_q <= c10;
            r11_q <= c11;
            state <= S_DONE;
          end else begin
            drain_cnt <= drain_cnt + 8'd1;
          end
        end
        S_DONE: begin
          if (host.res_ready) begin
            activation <= 1'b0;
            state      <= S_IDLE;
          end
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

`ifdef SYSTOLIC_FEEDER_JOBCNT_EN
  // Completed-job counter; wraps naturally at 16 bits.
  always_ff @(posedge clk) begin
    if (!rst) begin
      job_count <= 16'd0;
    end else if (handshake) begin
      job_count <= job_count + 16'd1;
    end
  end
`endif

  // Array drive decoded from the registered state. The skew puts the A row-1
  // and B column-1 streams one beat behind row/column 0, so PE(i,j) meets
  // A(i,k) and B(k,j) on the same cycle after the in-array forwarding delay.
  always_comb begin
    clear   = 1'b0;
    a_data0 = '0;
    a_data1 = '0;
    b_data0 = '0;
    b_data1 = '0;
    case (state)
      S_CLEAR: begin
        clear = 1'b1;
      end
      S_FEED: begin
        case (step)
          2'd0: begin
            a_data0 = mat[A00];
            b_data0 = mat[B00];
          end
          2'd1: begin
            a_data0 = mat[A01];
            a_data1 = mat[A10];
            b_data0 = mat[B10];
            b_data1 = mat[B01];
          end
          2'd2: begin
            a_data1 = mat[A11];
            b_data1 = mat[B11];
          end
          default: begin
            a_data0 = '0;
          end
        endcase
      end
      default: begin
        clear = 1'b0;
      end
    endcase
  end

  assign host.busy      = (state != S_IDLE);
  assign host.res_valid = (state == S_DONE);
  assign host.r00       = r00_q;
  assign host.r01       = r01_q;
  assign host.r10       = r10_q;
  assign host.r11       = r11_q;

endmodule

// File: tb/tb_systolic_feeder_2x2.sv
// ---------------------------------------------------------------------------
// tb_systolic_feeder_2x2
//
// Drives the feeder through directed jobs against a behavioural 2x2
// output-stationary array. Expected results come from a plain matrix
// multiply of the bench's own copy of A and B, queued at start and popped
// at the result handshake.
// ---------------------------------------------------------------------------
module tb_systolic_feeder_2x2;

  localparam int WIDTH        = 8;
  localparam int DRAIN_CYCLES = 2;
  localparam int RES_CYCLE    = 5 + DRAIN_CYCLES;

  logic clk = 1'b0;
  logic rst = 1'b0;

  always #5 clk = ~clk;

  systolic_feeder_2x2_if #(.WIDTH(WIDTH)) host();

  logic              clear;
  logic              activation;
  logic [WIDTH-1:0]  a_data0;
  logic [WIDTH-1:0]  a_data1;
  logic [WIDTH-1:0]  b_data0;
  logic [WIDTH-1:0]  b_data1;
  logic [15:0]       c00;
  logic [15:0]       c01;
  logic [15:0]       c10;
  logic [15:0]       c11;
`ifdef SYSTOLIC_FEEDER_JOBCNT_EN
  logic [15:0]       job_count;
  int                exp_jobs = 0;
`endif

  systolic_feeder_2x2 #(
    .WIDTH(WIDTH),
    .DRAIN_CYCLES(DRAIN_CYCLES)
  ) dut (
    .clk(clk),
    .rst(rst),
    .host(host),
    .clear(clear),
    .activation(activation),
    .a_data0(a_data0),
    .a_data1(a_data1),
    .b_data0(b_data0),
    .b_data1(b_data1),
    .c00(c00),
    .c01(c01),
    .c10(c10),
    .c11(c11)
`ifdef SYSTOLIC_FEEDER_JOBCNT_EN
    ,
    .job_count(job_count)
`endif
  );

  // Behavioural array: operands move right (a) and down (b) one PE per
  // cycle, each PE accumulates its product, ReLU applied on the outputs.
  logic signed [15:0] acc [4];
  logic [7:0] h00, h10, v00, v01;

  function automatic logic signed [15:0] mul(input logic [7:0] x, input logic [7:0] y);
    int xi;
    int yi;
    xi = $signed(x);
    yi = $signed(y);
    return 16'(xi * yi);
  endfunction

  function automatic logic [15:0] relu16(input logic signed [15:0] v, input logic act);
    return (act && v < 0) ? 16'd0 : v;
  endfunction

  always @(posedge clk) begin
    h00 <= a_data0;
    h10 <= a_data1;
    v00 <= b_data0;
    v01 <= b_data1;
    if (clear) begin
      acc[0] <= '0;
      acc[1] <= '0;
      acc[2] <= '0;
      acc[3] <= '0;
    end else begin
      acc[0] <= acc[0] + mul(a_data0, b_data0);
      acc[1] <= acc[1] + mul(h00, b_data1);
      acc[2] <= acc[2] + mul(a_data1, v00);
      acc[3] <= acc[3] + mul(h10, v01);
    end
  end

  assign c00 = relu16(acc[0], activation);
  assign c01 = relu16(acc[1], activation);
  assign c10 = relu16(acc[2], activation);
  assign c11 = relu16(acc[3], activation);

  // Scoreboard and bench copy of the matrices
  logic [63:0] sb [$];
  int          am [4];
  int          bm [4];
  int          compared   = 0;
  int          mismatched = 0;
  logic [63:0] last_result;

  function automatic logic [63:0] expectedResult(input bit relu);
    logic [63:0] packed_res;
    int          s;
    packed_res = '0;
    for (int i = 0; i < 2; i++) begin
      for (int j = 0; j < 2; j++) begin
        s = am[i*2] * bm[j] + am[i*2+1] * bm[2+j];
        if (relu && s < 0) s = 0;
        packed_res[(3 - (i*2+j))*16 +: 16] = 16'(s);
      end
    end
    return packed_res;
  endfunction

  function automatic logic [31:0] expectedBeat(input int cyc);
    case (cyc)
      2: return {8'(am[0]), 8'd0, 8'(bm[0]), 8'd0};
      3: return {8'(am[1]), 8'(am[2]), 8'(bm[2]), 8'(bm[1])};
      4: return {8'd0, 8'(am[3]), 8'd0, 8'(bm[3])};
      default: return 32'd0;
    endcase
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One matrix register write, driven at a falling edge.
  task automatic applyStimulus(input logic [2:0] addr, input int value);
    host.load_en   = 1'b1;
    host.load_addr = addr;
    host.load_data = 8'(value);
    if (addr < 4) am[addr] = value;
    else bm[addr - 4] = value;
    @(negedge clk);
    host.load_en = 1'b0;
  endtask

  task automatic loadMatrices(input int a [4], input int b [4]);
    for (int i = 0; i < 4; i++) applyStimulus(3'(i), a[i]);
    for (int i = 0; i < 4; i++) applyStimulus(3'(i + 4), b[i]);
  endtask

  task automatic runJob(input bit relu, input int stall, input bit with_load,
                        input logic [2:0] ld_addr, input int ld_data);
    int cyc;
    if (with_load) begin
      host.load_en   = 1'b1;
      host.load_addr = ld_addr;
      host.load_data = 8'(ld_data);
      if (ld_addr < 4) am[ld_addr] = ld_data;
      else bm[ld_addr - 4] = ld_data;
    end
    host.start     = 1'b1;
    host.relu_en   = relu;
    host.res_ready = (stall == 0);
    sb.push_back(expectedResult(relu));
    @(negedge clk);
    host.start   = 1'b0;
    host.load_en = 1'b0;
    host.relu_en = 1'b0;
    cyc = 1;
    while (host.res_valid !== 1'b1 && cyc < 40) begin
      checkOutput("clear", clear, (cyc == 1));
      checkOutput("beat", {a_data0, a_data1, b_data0, b_data1}, expectedBeat(cyc));
      checkOutput("busy", host.busy, 1'b1);
      checkOutput("activation", activation, relu);
      @(negedge clk);
      cyc++;
    end
    checkOutput("latency", cyc, RES_CYCLE);
    for (int k = 0; k < stall; k++) begin
      checkOutput("stall_valid", host.res_valid, 1'b1);
      checkOutput("stall_hold", {host.r00, host.r01, host.r10, host.r11}, sb[0]);
      checkOutput("stall_act", activation, relu);
      if (k == 1) begin
        host.start     = 1'b1;
        host.load_en   = 1'b1;
        host.load_addr = 3'd0;
        host.load_data = 8'd99;
      end else begin
        host.start   = 1'b0;
        host.load_en = 1'b0;
      end
      @(negedge clk);
    end
    host.start     = 1'b0;
    host.load_en   = 1'b0;
    host.res_ready = 1'b1;
    checkOutput("res_valid", host.res_valid, 1'b1);
    last_result = {host.r00, host.r01, host.r10, host.r11};
    checkOutput("result", last_result, sb.pop_front());
    @(negedge clk);
`ifdef SYSTOLIC_FEEDER_JOBCNT_EN
    exp_jobs++;
`endif
    checkOutput("busy_after", host.busy, 1'b0);
    checkOutput("valid_after", host.res_valid, 1'b0);
    checkOutput("act_after", activation, 1'b0);
    if (stall > 0) begin
      @(negedge clk);
      checkOutput("no_retrigger", host.busy, 1'b0);
    end
  endtask

  task automatic checkAllReset(input string tag);
    checkOutput({tag, "_busy"}, host.busy, 1'b0);
    checkOutput({tag, "_valid"}, host.res_valid, 1'b0);
    checkOutput({tag, "_clear"}, clear, 1'b0);
    checkOutput({tag, "_act"}, activation, 1'b0);
    checkOutput({tag, "_ab"}, {a_data0, a_data1, b_data0, b_data1}, 64'd0);
    checkOutput({tag, "_r"}, {host.r00, host.r01, host.r10, host.r11}, 64'd0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int a1 [4] = '{1, 2, 3, 4};
    int b1 [4] = '{5, 6, 7, 8};
    int a2 [4] = '{-1, 0, 0, 1};
    int b2 [4] = '{2, 0, 0, 3};
    int a7 [4] = '{1, 2, 3, 4};
    int b7 [3] = '{5, 6, 7};

    host.load_en   = 1'b0;
    host.load_addr = 3'd0;
    host.load_data = '0;
    host.start     = 1'b0;
    host.relu_en   = 1'b0;
    host.res_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      am[i] = 0;
      bm[i] = 0;
    end

    // Reset state
    repeat (2) @(negedge clk);
    checkAllReset("reset");
`ifdef SYSTOLIC_FEEDER_JOBCNT_EN
    checkOutput("jobcnt_reset", job_count, 16'd0);
`endif
    rst = 1'b1;
    @(negedge clk);

    // Basic job: C = [[19,22],[43,50]]
    $display("[TB] job 1: basic multiply");
    loadMatrices(a1, b1);
    runJob(1'b0, 0, 1'b0, 3'd0, 0);
    checkOutput("job1_literal", last_result, {16'd19, 16'd22, 16'd43, 16'd50});

    // Signed operands with and without ReLU
    $display("[TB] jobs 2-3: signed / ReLU");
    loadMatrices(a2, b2);
    runJob(1'b1, 0, 1'b0, 3'd0, 0);
    checkOutput("relu_literal", last_result, {16'd0, 16'd0, 16'd0, 16'd3});
    runJob(1'b0, 0, 1'b0, 3'd0, 0);
    checkOutput("norelu_literal", last_result, {16'hFFFE, 16'd0, 16'd0, 16'd3});
`ifdef SYSTOLIC_FEEDER_JOBCNT_EN
    checkOutput("jobcnt_three", job_count, 16'(exp_jobs));
`endif

    // Back-pressure with ignored start/load, then reuse without reload
    $display("[TB] job 4-5: stall and reuse");
    runJob(1'b0, 5, 1'b0, 3'd0, 0);
    runJob(1'b0, 0, 1'b0, 3'd0, 0);
    checkOutput("reuse_literal", last_result, {16'hFFFE, 16'd0, 16'd0, 16'd3});

    // Reset during feed step 1
    $display("[TB] reset mid-job");
    loadMatrices(a1, b1);
    host.start   = 1'b1;
    host.relu_en = 1'b1;
    @(negedge clk);
    host.start   = 1'b0;
    host.relu_en = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checkOutput("midjob_step1", {a_data0, a_data1, b_data0, b_data1}, expectedBeat(3));
    rst = 1'b0;
    @(negedge clk);
    checkAllReset("midreset");
`ifdef SYSTOLIC_FEEDER_JOBCNT_EN
    exp_jobs = 0;
    checkOutput("jobcnt_midreset", job_count, 16'd0);
`endif
    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      am[i] = 0;
      bm[i] = 0;
    end
    @(negedge clk);

    // Registers were wiped, so a job without reload yields zeros
    runJob(1'b0, 0, 1'b0, 3'd0, 0);
    checkOutput("zero_literal", last_result, 64'd0);

    // Fresh load whose last write coincides with start
    $display("[TB] load+start same cycle");
    for (int i = 0; i < 4; i++) applyStimulus(3'(i), a7[i]);
    for (int i = 0; i < 3; i++) applyStimulus(3'(i + 4), b7[i]);
    runJob(1'b0, 0, 1'b1, 3'd7, 8);
    checkOutput("fresh_literal", last_result, {16'd19, 16'd22, 16'd43, 16'd50});
`ifdef SYSTOLIC_FEEDER_JOBCNT_EN
    checkOutput("jobcnt_final", job_count, 16'(exp_jobs));
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
